dshot_tx_multi: RTL and testbench
=================================

# dshot_tx_multi

Multi-channel, parameterised DShot frame transmitter for the motor-drive path. It accepts one 11-bit throttle/command word and one telemetry-request bit per channel, and builds each 16-bit DShot packet with its 4-bit checksum. It then bit-bangs all channels in lockstep with configurable bit timing and a guaranteed inter-frame gap. It supersedes the single-channel, fixed-ratio packet/bit-bang pair and sits between the flight-control throttle registers and the ESC output pins.

## Interface
- CHANNELS, 4: number of independent motor outputs (1..8).
- BIT_PERIOD, 24: clocks per DShot bit.
- T1H, 18: high clocks for a '1' bit.
- T0H, 9: high clocks for a '0' bit.
- GAP_CYCLES, 32: minimum low clocks after bit 15 before `done` (0 allowed).
- Legal parameter set: 0 < T0H < T1H < BIT_PERIOD. Any other set is a parameter error and must fail elaboration.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- throttle  in  11*CHANNELS  channel n occupies bits [11n+10:11n]. Values 0..47 are commands, 48..2047 are throttle.
- telem  in  CHANNELS  per-channel telemetry-request bit.
- start  in  1  single-cycle frame request.
- busy  out  1  frame in progress (bits or gap).
- done  out  1  one-cycle pulse at frame completion.
- out  out  CHANNELS  DShot line per channel, idle low.

## Operation
- Packet per channel:
  - d[11:0] = {throttle_n, telem_n}.
  - csum = d[11:8] ^ d[7:4] ^ d[3:0].
  - pkt = {d, csum}.
  - The telemetry bit comes only from `telem`; it is never derived from the throttle value.
- Transmission is MSB first (pkt[15] first).
- Bit encoding: line high for T1H clocks (bit = 1) or T0H clocks (bit = 0), then low for the remainder of BIT_PERIOD.
- All channels share one bit counter and one cycle counter, so edges are simultaneous across channels.
- States:
  - IDLE: out = 0, busy = 0. When `start` = 1, latch all `throttle`/`telem` into packet registers and go to SEND.
  - SEND: cycle counter runs 0..BIT_PERIOD-1 and bit index runs 15..0. out[n] = (cycle < (pkt_n[bit] ? T1H : T0H)). When cycle = BIT_PERIOD-1 at bit 0, go to GAP, or to DONE if GAP_CYCLES = 0.
  - GAP: out = 0, count GAP_CYCLES clocks, then go to DONE.
  - DONE: a single cycle with done = 1, busy = 0, out = 0, then IDLE. `start` is accepted in this cycle (back-to-back frames).
- Inputs are sampled only at acceptance. Changes to `throttle`/`telem` during a frame do not affect it.
- `start` while busy = 1 is ignored; it is neither queued nor allowed to corrupt the frame.
- Counter widths are $clog2 of BIT_PERIOD / GAP_CYCLES (minimum 1 bit). No wrap is visible: counters reset at each state entry.
- Reset mid-frame forces out = 0, busy = 0, done = 0 and state IDLE immediately (asynchronous), with no partial pulse stretched. Packet registers reset to 0.

## Timing
- Reset values: out = 0, busy = 0, done = 0.
- `start` is sampled high in cycle 0 (IDLE or DONE).
- Cycle 1 is the first clock of bit 15: busy = 1, and out = 1 on every channel.
- Bit k (k = 15..0) occupies cycles 1+(15-k)*BIT_PERIOD .. (16-k)*BIT_PERIOD.
- The gap occupies cycles 16*BIT_PERIOD+1 .. 16*BIT_PERIOD+GAP_CYCLES.
- done = 1 and busy = 0 at cycle 16*BIT_PERIOD+GAP_CYCLES+1.
- Start-to-done latency: 16*BIT_PERIOD+GAP_CYCLES+1 clocks.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Test plan
Test parameters: CHANNELS=4, BIT_PERIOD=8, T1H=6, T0H=3, GAP_CYCLES=4.

- **Mixed packets.** ch0 = 1046/telem0, ch1 = 0/0, ch2 = 2047/1, ch3 = 48/1; pulse start.
  - Decoded packets are 0x82C6, 0x0000, 0xFFFF and 0x0617.
  - Every '1' is high for 6 cycles, every '0' for 3; each bit period is 8 cycles.
- **Frame timing.** Start at cycle 0.
  - busy = 1 over cycles 1..132.
  - out = 0 on all channels over cycles 129..132.
  - done = 1 only at cycle 133.
- **Back-to-back.** Start held high continuously.
  - Second frame's bit 15 rises at cycle 134.
  - Exactly one done per frame.
  - Starts during busy produce no extra frames.
- **Input stability.** Change throttle ch0 from 1046 to 5 at cycle 40.
  - The current frame still sends 0x82C6.
  - The next frame sends 0x00AA (5, telem 0).
- **Reset mid-frame.** Assert Reset at cycle 70 for 2 cycles.
  - out, busy and done drop to 0 asynchronously.
  - No done pulse follows.
  - A start after release produces a full, correct frame.
- **Zero-gap build.** GAP_CYCLES=0: done at cycle 129, with out = 0 on that cycle.

Source files
------------

// File: rtl/dshot_tx_multi.sv
// Multi-channel DShot transmitter: latches throttle/telemetry per channel, appends the checksum, and sends all channels in lockstep.
// Start-to-done latency is 16*BIT_PERIOD+GAP_CYCLES+1 clocks; start is ignored while busy and is never queued.
module dshot_tx_multi #(
    parameter int CHANNELS   = 4,
    parameter int BIT_PERIOD = 24,
    parameter int T1H        = 18,
    parameter int T0H        = 9,
    parameter int GAP_CYCLES = 32
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [11*CHANNELS-1:0]  throttle,
    input  logic [CHANNELS-1:0]     telem,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [CHANNELS-1:0]     out
);
    if (CHANNELS < 1 || CHANNELS > 8 || T0H <= 0 || T1H <= T0H || BIT_PERIOD <= T1H || GAP_CYCLES < 0) begin : g_bad_params
        $error("dshot_tx_multi: illegal parameter set");
    end

    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] BP_LAST  = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam state_t AFTER_SEND = (GAP_CYCLES == 0) ? ST_DONE : ST_GAP;

    function automatic logic [15:0] build_pkt(input logic [10:0] thr, input logic tlm);
        logic [11:0] d;
        d = {thr, tlm};
        return {d, d[11:8] ^ d[7:4] ^ d[3:0]};
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [3:0]              bit_q, bit_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [16*CHANNELS-1:0]  pkt_q, pkt_d, pkt_new;
    logic [CHANNELS-1:0]     out_q, out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        pkt_d   = pkt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SEND;
                    cyc_d   = '0;
                    bit_d   = 4'd15;
                    pkt_d   = pkt_new;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cyc_q == BP_LAST) begin
                    cyc_d = '0;
                    if (bit_q == 4'd0) begin
                        state_d = AFTER_SEND;
                        gap_d   = '0;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are derived from the next state so they can be registered without a cycle of lag.
        busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [15:0]   word;
        logic [CW-1:0] high_len;
        assign pkt_new[16*g +: 16] = build_pkt(throttle[11*g +: 11], telem[g]);
        assign word                = pkt_d[16*g +: 16];
        assign high_len            = word[bit_d] ? T1H_C : T0H_C;
        assign out_d[g]            = (state_d == ST_SEND) && (cyc_d < high_len);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            pkt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            pkt_q   <= pkt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_dshot_tx_multi.sv
// Bench for dshot_tx_multi: directed test-plan scenarios plus random traffic, checked every cycle
// against a frame-position model, with a second instance built for a zero-length gap.
module tb_dshot_tx_multi;
    localparam int BP  = 8;
    localparam int T1  = 6;
    localparam int T0  = 3;
    localparam int GAP = 4;
    localparam int DONE_M = 16*BP + GAP + 1;
    localparam int DONE_Z = 16*BP + 1;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [43:0] throttle;
    logic [3:0]  telem;
    logic        start, start_z;
    logic        busy, done, busy_z, done_z;
    logic [3:0]  out, out_z;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int ndone    = 0;

    int          m_rel = 0, z_rel = 0;
    logic [63:0] m_pk = '0, z_pk = '0;
    int          hc[4];
    logic [15:0] acc[4];
    logic [15:0] dec_pkt[4];

    dshot_tx_multi #(.CHANNELS(4), .BIT_PERIOD(BP), .T1H(T1), .T0H(T0), .GAP_CYCLES(GAP)) dut (
        .Clock(Clock), .Reset(Reset), .throttle(throttle), .telem(telem),
        .start(start), .busy(busy), .done(done), .out(out)
    );

    dshot_tx_multi #(.CHANNELS(4), .BIT_PERIOD(BP), .T1H(T1), .T0H(T0), .GAP_CYCLES(0)) dut_z (
        .Clock(Clock), .Reset(Reset), .throttle(throttle), .telem(telem),
        .start(start_z), .busy(busy_z), .done(done_z), .out(out_z)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_pkt(input int thr, input int t);
        int d, cs;
        d  = thr * 2 + t;
        cs = ((d >> 8) ^ (d >> 4) ^ d) & 15;
        return 16'(d * 16 + cs);
    endfunction

    // Expected {done, busy, out} for a frame position (0 = idle, 1 = first clock of bit 15).
    function automatic logic [5:0] exp_vec(input int rel, input int gap, input logic [63:0] pk);
        logic [3:0] o;
        int k, pos;
        o = '0;
        if (rel >= 1 && rel <= 16*BP) begin
            k   = 15 - (rel - 1) / BP;
            pos = (rel - 1) % BP;
            for (int ch = 0; ch < 4; ch++) o[ch] = pos < (pk[ch*16 + k] ? T1 : T0);
        end
        return {rel == 16*BP + gap + 1, rel >= 1 && rel <= 16*BP + gap, o};
    endfunction

    function automatic int next_rel(input int rel, input logic st, input int done_rel);
        if (st && (rel == 0 || rel == done_rel)) return 1;
        if (rel == 0 || rel == done_rel) return 0;
        return rel + 1;
    endfunction

    function automatic logic [63:0] cur_pkts();
        logic [63:0] p;
        for (int ch = 0; ch < 4; ch++) p[ch*16 +: 16] = mk_pkt(int'(throttle[11*ch +: 11]), int'(telem[ch]));
        return p;
    endfunction

    always @(negedge Clock) begin
        logic [5:0] e, ez;
        int pos;
        if (Reset) begin
            e  = '0;
            ez = '0;
        end else begin
            e  = exp_vec(m_rel, GAP, m_pk);
            ez = exp_vec(z_rel, 0, z_pk);
        end
        check_eq("main_outputs", {done, busy, out}, e);
        check_eq("zgap_outputs", {done_z, busy_z, out_z}, ez);
        if (done) ndone++;
        if (!Reset && m_rel >= 1 && m_rel <= 16*BP) begin
            pos = (m_rel - 1) % BP;
            for (int ch = 0; ch < 4; ch++) begin
                if (pos == 0) hc[ch] = 0;
                if (out[ch]) hc[ch]++;
                if (pos == BP - 1) begin
                    check_eq("bit_width", (hc[ch] == T1 || hc[ch] == T0), 1);
                    acc[ch] = {acc[ch][14:0], hc[ch] >= T1};
                    if (m_rel == 16*BP) begin
                        dec_pkt[ch] = acc[ch];
                        check_eq("decoded_vs_model", acc[ch], m_pk[ch*16 +: 16]);
                    end
                end
            end
        end
        if (Reset) begin
            m_rel = 0; z_rel = 0; m_pk = '0; z_pk = '0;
        end else begin
            m_rel = next_rel(m_rel, start, DONE_M);
            if (m_rel == 1) m_pk = cur_pkts();
            z_rel = next_rel(z_rel, start_z, DONE_Z);
            if (z_rel == 1) z_pk = cur_pkts();
        end
    end

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic set_thr(input int ch, input int v);
        throttle[11*ch +: 11] = 11'(v);
    endtask

    task automatic wait_done(input int limit, output int at, output int at_z, output logic [3:0] oz);
        at = -1; at_z = -1; oz = 4'hF;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge Clock);
            if (done_z && at_z < 0) begin
                at_z = cyc;
                oz   = out_z;
            end
            if (done) at = cyc;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, at, atz, base;
        logic [3:0] oz;
        Reset = 1'b1; start = 1'b0; start_z = 1'b0; throttle = '0; telem = '0;
        repeat (3) step();
        check_eq("reset_out", out, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        Reset = 1'b0;
        step();

        // Mixed packets, frame timing, zero-gap instance
        set_thr(0, 1046); set_thr(1, 0); set_thr(2, 2047); set_thr(3, 48);
        telem = 4'b1100;
        start = 1'b1; start_z = 1'b1; s = cyc;
        step();
        start = 1'b0; start_z = 1'b0;
        wait_done(300, at, atz, oz);
        check_eq("done_latency", at - s, DONE_M);
        check_eq("zgap_done_latency", atz - s, DONE_Z);
        check_eq("zgap_out_at_done", oz, 0);
        check_eq("pkt_ch0", dec_pkt[0], 16'h82C6);
        check_eq("pkt_ch1", dec_pkt[1], 16'h0000);
        check_eq("pkt_ch2", dec_pkt[2], 16'hFFFF);
        check_eq("pkt_ch3", dec_pkt[3], 16'h0617);
        step();

        // Back-to-back with start held, throttle ch0 changed mid-frame
        start = 1'b1; s = cyc; base = ndone;
        repeat (40) step();
        set_thr(0, 5);
        wait_done(300, at, atz, oz);
        check_eq("b2b_first_done", at - s, DONE_M);
        check_eq("stable_ch0", dec_pkt[0], 16'h82C6);
        step();
        @(negedge Clock);
        check_eq("b2b_rise_cycle", cyc - s, DONE_M + 1);
        check_eq("b2b_rise_out", out, 4'hF);
        step();
        start = 1'b0;
        wait_done(300, at, atz, oz);
        check_eq("b2b_second_done", at - s, 2*DONE_M);
        check_eq("next_ch0", dec_pkt[0], 16'h00AA);
        repeat (20) step();
        check_eq("b2b_done_count", ndone - base, 2);

        // Reset mid-frame
        set_thr(0, 1046);
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        repeat (69) step();
        check_eq("pre_reset_busy", busy, 1);
        check_eq("pre_reset_out2", out[2], 1);
        Reset = 1'b1;
        #1;
        check_eq("async_out", out, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_done", done, 0);
        step(); step();
        Reset = 1'b0;
        base = ndone;
        repeat (150) step();
        check_eq("no_done_after_reset", ndone - base, 0);
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        wait_done(300, at, atz, oz);
        check_eq("post_reset_latency", at - s, DONE_M);
        check_eq("post_reset_ch0", dec_pkt[0], 16'h82C6);
        check_eq("post_reset_ch3", dec_pkt[3], 16'h0617);

        // Random traffic: random starts (including while busy) and input changes mid-frame
        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 15) == 0);
            start_z = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) throttle = 44'({$urandom(), $urandom()});
            if ($urandom_range(0, 31) == 0) telem = 4'($urandom());
            step();
        end
        start = 1'b0; start_z = 1'b0;
        repeat (300) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
